// File: rtl/debounce_ctrl.sv
// Debounce filter for one raw level input: synchronizer, then a 4-state FSM with a
// stability counter. A level change reaches q only after STABLE_CYCLES consecutive
// equal synchronized samples. rise/fall are one-cycle strobes aligned with the q change.
module debounce_ctrl #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        SLow  = 2'd0,
        SChkH = 2'd1,
        SHigh = 2'd2,
        SChkL = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CntZero = '0;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   din_s;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_q;
    logic             rise_q;
    logic             fall_q;
    logic             busy_q;

    // Synchronizer chain; free-running, not gated by en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign din_s = sync_q[SYNC_STAGES-1];

    // Qualification FSM with registered level, strobes and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLow;
            cnt_q   <= CntZero;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // Strobes last one cycle unless re-asserted below.
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                SLow: begin
                    if (en && din_s) begin
                        state_q <= SChkH;
                        cnt_q   <= CntOne;
                        busy_q  <= 1'b1;
                    end
                end
                SChkH: begin
                    // A reverting sample beats a completing count.
                    if (!din_s || !en) begin
                        state_q <= SLow;
                        cnt_q   <= CntZero;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CntLast) begin
                        state_q <= SHigh;
                        cnt_q   <= CntZero;
                        q_q     <= 1'b1;
                        rise_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                SHigh: begin
                    if (en && !din_s) begin
                        state_q <= SChkL;
                        cnt_q   <= CntOne;
                        busy_q  <= 1'b1;
                    end
                end
                SChkL: begin
                    if (din_s || !en) begin
                        state_q <= SHigh;
                        cnt_q   <= CntZero;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CntLast) begin
                        state_q <= SLow;
                        cnt_q   <= CntZero;
                        q_q     <= 1'b0;
                        fall_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                default: begin
                    state_q <= SLow;
                    cnt_q   <= CntZero;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_debounce_ctrl.sv
// Bench for debounce_ctrl: directed scenarios followed by a randomized phase, all
// compared every cycle against a run-length reference model of the filter.
module tb_debounce_ctrl;

    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned STABLE_CYCLES = 4;
    localparam int unsigned CNT_W         = 8;

    logic clk;
    logic rst;
    logic din;
    logic en;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    int n_checks = 0;
    int n_errors = 0;

    debounce_ctrl #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .en  (en),
        .q   (q),
        .rise(rise),
        .fall(fall),
        .busy(busy)
    );

    // 50 MHz clock.
    always #10 clk = ~clk;

    // Reference model: din_s is din seen SYNC_STAGES edges ago; q flips once the
    // run of enabled samples differing from q reaches STABLE_CYCLES.
    logic [SYNC_STAGES-1:0] sh_m;
    logic                   q_m;
    logic                   rise_m;
    logic                   fall_m;
    int                     run_m;
    logic                   busy_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_m   <= '0;
            q_m    <= 1'b0;
            rise_m <= 1'b0;
            fall_m <= 1'b0;
            run_m  <= 0;
        end else begin
            sh_m   <= {sh_m[SYNC_STAGES-2:0], din};
            rise_m <= 1'b0;
            fall_m <= 1'b0;
            if (en && (sh_m[SYNC_STAGES-1] != q_m)) begin
                if (run_m + 1 == int'(STABLE_CYCLES)) begin
                    q_m    <= ~q_m;
                    rise_m <= ~q_m;
                    fall_m <= q_m;
                    run_m  <= 0;
                end else begin
                    run_m <= run_m + 1;
                end
            end else begin
                run_m <= 0;
            end
        end
    end

    assign busy_m = (run_m != 0);

    task automatic cmp(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and compare all outputs to the model.
    task automatic cyc(input string tag);
        @(negedge clk);
        cmp({tag, " q"}, q, q_m);
        cmp({tag, " rise"}, rise, rise_m);
        cmp({tag, " fall"}, fall, fall_m);
        cmp({tag, " busy"}, busy, busy_m);
    endtask

    initial begin
        int hold;
        clk = 1'b0;
        rst = 1'b1;
        din = 1'b0;
        en  = 1'b1;

        // T1: reset held 200 ns with din toggling.
        for (int i = 0; i < 10; i++) begin
            cyc("t1");
            cmp("t1 q0", q, 1'b0);
            cmp("t1 rise0", rise, 1'b0);
            cmp("t1 fall0", fall, 1'b0);
            cmp("t1 busy0", busy, 1'b0);
            din = ~din;
            #3 din = ~din;
            #2 din = ~din;
        end
        din = 1'b0;
        rst = 1'b0;
        repeat (4) cyc("t1 settle");

        // T2: din 0->1, q rises on 6th edge, busy the 3 cycles before.
        din = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cyc($sformatf("t2 k%0d", k));
            if (k <= 2) cmp($sformatf("t2 busy k%0d", k), busy, 1'b0);
            if (k >= 3 && k <= 5) cmp($sformatf("t2 busy k%0d", k), busy, 1'b1);
            if (k <= 5) cmp($sformatf("t2 q k%0d", k), q, 1'b0);
            if (k == 6) begin
                cmp("t2 q6", q, 1'b1);
                cmp("t2 rise6", rise, 1'b1);
                cmp("t2 busy6", busy, 1'b0);
            end
            if (k == 7) cmp("t2 rise7", rise, 1'b0);
        end

        // T3: sub-cycle glitches and 1..3 clock low pulses are rejected.
        for (int i = 0; i < 3; i++) begin
            cyc("t3 glitch");
            din = 1'b0;
            #2 din = 1'b1;
            cmp("t3 glitch q", q, 1'b1);
            cmp("t3 glitch fall", fall, 1'b0);
        end
        for (int w = 1; w <= 3; w++) begin
            din = 1'b0;
            for (int k = 0; k < w; k++) begin
                cyc("t3 pulse");
                cmp($sformatf("t3 w%0d q", w), q, 1'b1);
                cmp($sformatf("t3 w%0d fall", w), fall, 1'b0);
            end
            din = 1'b1;
            for (int k = 0; k < 7; k++) begin
                cyc("t3 recover");
                cmp($sformatf("t3 w%0d rq", w), q, 1'b1);
                cmp($sformatf("t3 w%0d rfall", w), fall, 1'b0);
            end
        end
        // A 4-clock low pulse is accepted.
        din = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc($sformatf("t3 p4 k%0d", k));
            if (k == 4) din = 1'b1;
            if (k < 6) begin
                cmp($sformatf("t3 p4 q k%0d", k), q, 1'b1);
                cmp($sformatf("t3 p4 fall k%0d", k), fall, 1'b0);
            end
            if (k == 6) begin
                cmp("t3 p4 q6", q, 1'b0);
                cmp("t3 p4 fall6", fall, 1'b1);
            end
            if (k == 7) cmp("t3 p4 fall7", fall, 1'b0);
        end
        repeat (8) cyc("t3 settle");

        // T4: dropping en mid-check aborts it; re-enable restarts a full count.
        din = 1'b0;
        repeat (10) cyc("t4 low");
        din = 1'b1;
        repeat (3) cyc("t4 chk");
        cmp("t4 busy mid", busy, 1'b1);
        en = 1'b0;
        cyc("t4 en0");
        cmp("t4 abort busy", busy, 1'b0);
        cmp("t4 abort q", q, 1'b0);
        cmp("t4 abort rise", rise, 1'b0);
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc($sformatf("t4 k%0d", k));
            if (k < 4) cmp($sformatf("t4 q k%0d", k), q, 1'b0);
            else begin
                cmp("t4 q4", q, 1'b1);
                cmp("t4 rise4", rise, 1'b1);
            end
        end

        // T5: asynchronous reset mid-check clears outputs before the next edge.
        din = 1'b0;
        repeat (10) cyc("t5 low");
        din = 1'b1;
        repeat (4) cyc("t5 chk");
        cmp("t5 busy mid", busy, 1'b1);
        #3 rst = 1'b1;
        #1;
        cmp("t5 async busy", busy, 1'b0);
        cmp("t5 async q", q, 1'b0);
        repeat (2) cyc("t5 rst");
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc($sformatf("t5 k%0d", k));
            if (k < 6) cmp($sformatf("t5 q k%0d", k), q, 1'b0);
            else begin
                cmp("t5 q6", q, 1'b1);
                cmp("t5 rise6", rise, 1'b1);
            end
        end

        // T6: din 1->0 held, fall on the 6th edge, rise never set.
        repeat (3) cyc("t6 pre");
        din = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc($sformatf("t6 k%0d", k));
            cmp($sformatf("t6 rise k%0d", k), rise, 1'b0);
            if (k < 6) cmp($sformatf("t6 q k%0d", k), q, 1'b1);
            if (k == 6) begin
                cmp("t6 q6", q, 1'b0);
                cmp("t6 fall6", fall, 1'b1);
            end
        end

        // Randomized phase: random levels, hold times, en drops and glitches.
        for (int s = 0; s < 80; s++) begin
            din  = 1'($urandom_range(0, 1));
            en   = ($urandom_range(0, 7) != 0);
            hold = int'($urandom_range(1, 7));
            for (int k = 0; k < hold; k++) begin
                cyc("rnd");
                cmp("rnd excl", rise & fall, 1'b0);
                if ($urandom_range(0, 5) == 0) begin
                    din = ~din;
                    #2 din = ~din;
                end
            end
        end
        en = 1'b1;
        repeat (10) cyc("rnd tail");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
